clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
Multi-channel, runtime-programmable clock divider. It replaces the fixed-DIVISOR divider in the SPI flash simulator. Each channel derives a divided clock, plus edge strobes, from clk_in. Divisors are written over a simple write port and take effect only at period boundaries, so a divisor change cannot produce a glitch. The block feeds SPI SCK generation and slow housekeeping timers.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 16, counter and divisor width in bits
RST_DIV, 2, divisor loaded into every channel at reset (must be >= 2 and < 2**CNT_W)

Ports:
clk_in  input  1  source clock; all logic on its rising edge (except the optional feature)
rst_n  input  1  asynchronous, active-low reset
en  input  NUM_CH  per-channel run enable
div_wr  input  1  one-cycle write strobe for a divisor
div_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write
div_val  input  CNT_W  new divisor value
div_err  output  1  registered one-cycle pulse: last write was rejected
div_pend  output  NUM_CH  a written divisor is waiting for the period boundary
clk_out  output  NUM_CH  divided clocks
rise_tick  output  NUM_CH  one-cycle strobe, same cycle clk_out goes 0->1
fall_tick  output  NUM_CH  one-cycle strobe, same cycle clk_out goes 1->0

Behaviour:
- Reset (async, rst_n=0) puts every channel in this state:
  - cnt=0, div=RST_DIV, div_pend=0
  - clk_out=0, rise_tick=0, fall_tick=0, div_err=0
  - All outputs are registered.
- Per enabled channel, each clk_in edge:
  - cnt_next = (cnt==div-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next >= div/2), using integer div/2.
  - Result: low for div/2 cycles, high for div-div/2 cycles, period = div cycles (low phase first).
- Ticks: rise_tick <= (cnt_next==div/2); fall_tick <= (cnt_next==0) while clk_out is 1.
- Disabled channel (en=0):
  - cnt and clk_out are forced to 0 on the next edge.
  - If clk_out was 1, a fall_tick is emitted; otherwise no ticks.
  - On re-enable, the channel restarts from cnt=0, so the first rising edge comes div/2 edges after en rises.
- Divisor write (div_wr=1):
  - If div_val<2 or div_ch>=NUM_CH: the write is rejected, div_err pulses the next cycle, and no state changes.
  - Otherwise div_val goes into the channel's pending register and div_pend is set.
  - A second write before the pending value is applied overwrites the pending value (last write wins).
- Applying a pending divisor:
  - Enabled channel: applied on the edge where cnt wraps (cnt==div-1 -> 0); the new div governs the next period; div_pend clears on that same edge.
  - Disabled channel: applied on the next edge.
  - A write in the same cycle as the wrap is not applied at that wrap; it waits for the next one.
- Wrap and divisor arithmetic is CNT_W bits. div = 2**CNT_W-1 is legal; cnt never exceeds div-1.

Optional Feature:
CLK_DIV_DUTY50_EN
- Defined:
  - Each channel adds a negedge-clk_in register that samples the posedge phase signal.
  - For odd div, clk_out = posedge phase AND negedge copy, which delays the rise by half a clk_in cycle.
  - Result is exactly 50% duty: div=3 gives 1.5 cycles low and 1.5 cycles high.
  - For even div, the negedge path is bypassed and the output is identical to the undefined case.
  - rise_tick and fall_tick stay posedge-timed and unchanged.
- Undefined: no negedge logic; odd divisors have a high phase one cycle longer than the low phase.

Decomposition:
- Package clk_div_pkg: MIN_DIV=2, default CNT_W, typedef div_t (logic [CNT_W-1:0]), and a function half(div) returning div/2.
- One sub-module, clk_div_ch, holds a single channel's counter, pending register, output and ticks.
- The top module does write decode, div_err generation, and the NUM_CH generate loop.

Test Plan:
- Reset release with en=1, RST_DIV=2 -> clk_out toggles every edge; rise_tick on edges 1, 3, 5…; fall_tick on edges 2, 4, 6…
- Write div_val=5 to channel 0 mid-period -> div_pend[0]=1 until the wrap; the next period is 5 cycles with 2 low and 3 high (macro undefined); channel 1 is unaffected.
- Write div_val=1, then div_ch=NUM_CH -> div_err pulses once per write; div and div_pend stay unchanged.
- Two writes (6, then 8) before the wrap -> 8 is applied at the wrap; a 6-cycle period is never observed.
- en dropped while clk_out=1, re-raised 3 cycles later with div=4 -> one fall_tick, clk_out held 0, first rise 2 edges after en rises.
- CLK_DIV_DUTY50_EN defined, div=3 -> high and low each 1.5 clk_in periods, measured at both clk_in edges; assert rst_n mid-period -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_pkg : shared constants and helpers for clk_div_multi        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package clk_div_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DEF_CNT_W = 16;

    typedef logic [DEF_CNT_W-1:0] div_t;

    function automatic div_t half(input div_t div);
        return div >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_ch : one divider channel (counter, pending divisor, ticks)  |
// | Optional: CLK_DIV_DUTY50_EN adds a negedge stage for 50% odd duty   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module clk_div_ch #(
    parameter int CNT_W   = 16,
    parameter int RST_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             pend,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_clk;
    logic             r_rise;
    logic             r_fall;

    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;

    assign w_half     = r_div >> 1;
    assign w_wrap     = (r_cnt == r_div - CNT_W'(1));
    assign w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= CNT_W'(RST_DIV);
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            if (en) begin
                r_cnt  <= w_cnt_next;
                r_clk  <= (w_cnt_next >= w_half);
                r_rise <= (w_cnt_next == w_half);
                r_fall <= (w_cnt_next == '0) && r_clk;
            end else begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= r_clk;
            end
            // Swap divisor only where the counter restarts, so no runt pulse.
            if (r_pend && (w_wrap || !en)) begin
                r_div  <= r_pend_val;
                r_pend <= 1'b0;
            end
            if (wr) begin
                r_pend_val <= wr_val;
                r_pend     <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic r_neg;

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) r_neg <= 1'b0;
        else        r_neg <= r_clk;
    end

    // Odd divisors: delay the rise by half a cycle, keep the posedge fall.
    assign clk_out = r_div[0] ? (r_clk & r_neg) : r_clk;
`else
    assign clk_out = r_clk;
`endif

    assign pend      = r_pend;
    assign rise_tick = r_rise;
    assign fall_tick = r_fall;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_multi : multi-channel programmable glitch-free divider      |
// | Optional: CLK_DIV_DUTY50_EN gives 50% duty on odd divisors          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH  = 2,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int RST_DIV = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_err,
    output logic [NUM_CH-1:0] div_pend,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] fall_tick
);

    logic r_err;
    logic w_reject;
    logic w_wr_ok;

    assign w_reject = (div_val < CNT_W'(MIN_DIV)) || (int'(div_ch) >= NUM_CH);
    assign w_wr_ok  = div_wr && !w_reject;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= div_wr && w_reject;
    end

    assign div_err = r_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .en        (en[i]),
            .wr        (w_wr_ok && (int'(div_ch) == i)),
            .wr_val    (div_val),
            .pend      (div_pend[i]),
            .clk_out   (clk_out[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_clk_div_multi : directed self-checking bench for clk_div_multi   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_clk_div_multi;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int RST_DIV = 2;
    localparam int CH_W    = 2;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic              div_err;
    logic [NUM_CH-1:0] div_pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rise_tick;
    logic [NUM_CH-1:0] fall_tick;

    int passed = 0;
    int total  = 0;

    clk_div_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_wr    (div_wr),
        .div_ch    (div_ch),
        .div_val   (div_val),
        .div_err   (div_err),
        .div_pend  (div_pend),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = CH_W'(ch);
        div_val = CNT_W'(val);
    endtask

    // {ch2,ch1,ch0} clk_out after edges 7..11: ch0 runs div=5, others div=2
    int exp_p5[5] = '{'b110, 'b001, 'b111, 'b001, 'b110};
`ifdef CLK_DIV_DUTY50_EN
    int exp_d3[8] = '{0, 1, 1, 1, 0, 0, 0, 1};
`else
    int exp_d3[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
`endif

    initial begin
        rst_n = 1'b1; en = '0; div_wr = 1'b0; div_ch = '0; div_val = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_clk",  32'(clk_out),   0);
        chk("rst_rise", 32'(rise_tick), 0);
        chk("rst_fall", 32'(fall_tick), 0);
        chk("rst_pend", 32'(div_pend),  0);
        chk("rst_err",  32'(div_err),   0);

        en = '1; rst_n = 1'b1;
        tick();
        chk("e1_clk",  32'(clk_out),   'b111);
        chk("e1_rise", 32'(rise_tick), 'b111);
        chk("e1_fall", 32'(fall_tick), 0);
        tick();
        chk("e2_clk",  32'(clk_out),   0);
        chk("e2_fall", 32'(fall_tick), 'b111);
        chk("e2_rise", 32'(rise_tick), 0);
        tick();
        chk("e3_rise", 32'(rise_tick), 'b111);
        tick();
        chk("e4_fall", 32'(fall_tick), 'b111);

        // div=5 on ch0 mid-period
        wr(0, 5);
        tick();
        chk("e5_pend", 32'(div_pend), 'b001);
        chk("e5_clk",  32'(clk_out),  'b111);
        div_wr = 1'b0;
        tick();
        chk("e6_pend", 32'(div_pend), 0);
        chk("e6_clk",  32'(clk_out),  0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("p5_clk_e%0d", k + 7), 32'(clk_out), 32'(exp_p5[k]));
        end

        // rejected writes
        wr(0, 1);
        tick();
        chk("e12_err",  32'(div_err),  1);
        chk("e12_pend", 32'(div_pend), 0);
        div_wr = 1'b0;
        tick();
        chk("e13_err", 32'(div_err), 0);
        wr(3, 7);
        tick();
        chk("e14_err",  32'(div_err),  1);
        chk("e14_pend", 32'(div_pend), 0);
        div_wr = 1'b0;
        tick();
        chk("e15_err", 32'(div_err), 0);
        chk("e15_clk", 32'(clk_out), 'b111);
        tick();
        chk("e16_fall", 32'(fall_tick), 'b111);
        chk("e16_clk",  32'(clk_out),   0);

        // last write wins: 6 then 8
        wr(0, 6);
        tick();
        wr(0, 8);
        tick();
        div_wr = 1'b0;
        tick(); tick();
        chk("e20_pend", 32'(div_pend), 'b001);
        tick();
        chk("e21_pend", 32'(div_pend),  0);
        chk("e21_fall", 32'(fall_tick), 'b001);
        tick(); tick(); tick();
        chk("e24_clk", 32'(clk_out), 0);
        tick();
        chk("e25_rise", 32'(rise_tick), 'b111);
        tick(); tick();
        chk("e27_clk", 32'(clk_out), 'b111);
        tick(); tick();
        chk("e29_fall", 32'(fall_tick), 'b001);

        // disable ch0 while high, load div=4, re-enable
        tick(); tick(); tick(); tick();
        chk("e33_clk", 32'(clk_out), 'b111);
        en[0] = 1'b0;
        wr(0, 4);
        tick();
        chk("e34_fall", 32'(fall_tick), 'b111);
        chk("e34_clk",  32'(clk_out),   0);
        chk("e34_pend", 32'(div_pend),  'b001);
        div_wr = 1'b0;
        tick();
        chk("e35_fall", 32'(fall_tick), 0);
        chk("e35_pend", 32'(div_pend),  0);
        chk("e35_clk",  32'(clk_out),   'b110);
        tick();
        chk("e36_clk", 32'(clk_out), 0);
        en[0] = 1'b1;
        tick();
        chk("e37_clk",  32'(clk_out),   'b110);
        chk("e37_rise", 32'(rise_tick), 'b110);
        tick();
        chk("e38_clk",  32'(clk_out),   'b001);
        chk("e38_rise", 32'(rise_tick), 'b001);

        // asynchronous reset mid-period
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk",  32'(clk_out),   0);
        chk("arst_rise", 32'(rise_tick), 0);
        chk("arst_fall", 32'(fall_tick), 0);
        chk("arst_pend", 32'(div_pend),  0);
        tick(); tick();

        // odd divisor 3 on ch2, sampled at both clock edges
        en = 'b011; rst_n = 1'b1;
        wr(2, 3);
        tick();
        chk("r1_pend", 32'(div_pend), 'b100);
        div_wr = 1'b0;
        tick();
        chk("r2_pend", 32'(div_pend), 0);
        en = '1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("d3_pos%0d", k), 32'(clk_out[2]), 32'(exp_d3[2*k]));
            #5;
            chk($sformatf("d3_neg%0d", k), 32'(clk_out[2]), 32'(exp_d3[2*k+1]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
